// File: rtl/encoder_mux_rr.sv
// encoder_mux_rr
//   Round-robin selector over NUM_ENC interleaved first-N priority-encoder
//   result streams. The encoder whose pass counter reaches SEL_PASS becomes
//   the selected source one cycle ahead of its data. The selected cluster set
//   is registered toward the merger. The trigger spacing is supervised by a
//   lock FSM, and collisions and sync errors are kept as sticky flags.
//
// Ports
//   clock4x     in   160 MHz clock
//   reset_n     in   synchronous active-low reset
//   enc_pass    in   pass counters; encoder k at [k*PASS_W +: PASS_W]
//   enc_adr     in   cluster addresses; encoder k, cluster j at
//                    [(k*NUM_CL+j)*ADR_W +: ADR_W]
//   enc_cnt     in   cluster sizes, packed like enc_adr
//   clr_err     in   clears collision_o and sync_err_o (a set in the same cycle wins)
//   sel_o       out  registered index of the selected encoder
//   adr_o       out  registered cluster addresses of the selected encoder
//   cnt_o       out  registered cluster sizes of the selected encoder
//   pass_o      out  registered pass count of the selected encoder
//   locked_o    out  trigger spacing is stable
//   collision_o out  sticky: several encoders triggered in one cycle
//   sync_err_o  out  sticky: spacing violated while locked
//
// Lock FSM
//   state       | meaning
//   ST_UNLOCKED | counting consecutive well-spaced triggers in lock_cnt
//   ST_LOCKED   | LOCK_COUNT well-spaced triggers seen; any bad or missing
//               | trigger drops lock and raises sync_err_o

module encoder_mux_rr #(
    parameter int NUM_ENC     = 2,
    parameter int NUM_CL      = 16,
    parameter int ADR_W       = 11,
    parameter int CNT_W       = 3,
    parameter int PASS_W      = 3,
    parameter int SEL_PASS    = 6,
    parameter int SLOT_CYCLES = 4,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                             clock4x,
    input  logic                             reset_n,
    input  logic [NUM_ENC*PASS_W-1:0]        enc_pass,
    input  logic [NUM_ENC*NUM_CL*ADR_W-1:0]  enc_adr,
    input  logic [NUM_ENC*NUM_CL*CNT_W-1:0]  enc_cnt,
    input  logic                             clr_err,
    output logic [$clog2(NUM_ENC)-1:0]       sel_o,
    output logic [NUM_CL*ADR_W-1:0]          adr_o,
    output logic [NUM_CL*CNT_W-1:0]          cnt_o,
    output logic [PASS_W-1:0]                pass_o,
    output logic                             locked_o,
    output logic                             collision_o,
    output logic                             sync_err_o
);

    localparam int SEL_W = $clog2(NUM_ENC);
    localparam int GAP_W = $clog2(2*SLOT_CYCLES) + 1;
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [GAP_W-1:0]  GAP_MAX  = {GAP_W{1'b1}};
    localparam logic [GAP_W-1:0]  GAP_SLOT = GAP_W'(SLOT_CYCLES);
    localparam logic [LCK_W-1:0]  LCK_LAST = LCK_W'(LOCK_COUNT - 1);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t              state;
    logic [NUM_ENC-1:0]       trig;
    logic                     any_trig;
    logic                     multi_trig;
    logic [SEL_W-1:0]         first_idx;
    logic [GAP_W-1:0]         gap;
    logic [LCK_W-1:0]         lock_cnt;
    logic                     primed;
    logic                     well_spaced;
    logic                     bad_event;
    logic [NUM_CL*ADR_W-1:0]  adr_mux;
    logic [NUM_CL*CNT_W-1:0]  cnt_mux;
    logic [PASS_W-1:0]        pass_mux;

    // Trigger decode and lowest-index priority pick
    always_comb begin
        trig      = '0;
        first_idx = '0;
        for (int k = NUM_ENC - 1; k >= 0; k--) begin
            trig[k] = (enc_pass[k*PASS_W +: PASS_W] == PASS_W'(SEL_PASS));
            if (trig[k]) begin
                first_idx = SEL_W'(k);
            end
        end
    end

    assign any_trig   = |trig;
    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi_trig = |(trig & (trig - NUM_ENC'(1)));

    // The first trigger after reset has no reference point, so it never counts
    // as well spaced even if gap happens to equal SLOT_CYCLES.
    assign well_spaced = primed && (gap == GAP_SLOT);
    assign bad_event   = any_trig ? !well_spaced : (gap > GAP_SLOT);

    // Source mux driven by the registered selection
    always_comb begin
        adr_mux  = '0;
        cnt_mux  = '0;
        pass_mux = '0;
        for (int k = 0; k < NUM_ENC; k++) begin
            if (sel_o == SEL_W'(k)) begin
                adr_mux  = enc_adr[k*NUM_CL*ADR_W +: NUM_CL*ADR_W];
                cnt_mux  = enc_cnt[k*NUM_CL*CNT_W +: NUM_CL*CNT_W];
                pass_mux = enc_pass[k*PASS_W +: PASS_W];
            end
        end
    end

    always_ff @(posedge clock4x) begin
        if (!reset_n) begin
            adr_o  <= '0;
            cnt_o  <= '0;
            pass_o <= '0;
        end else begin
            adr_o  <= adr_mux;
            cnt_o  <= cnt_mux;
            pass_o <= pass_mux;
        end
    end

    always_ff @(posedge clock4x) begin
        if (!reset_n) begin
            state       <= ST_UNLOCKED;
            sel_o       <= '0;
            gap         <= '0;
            lock_cnt    <= '0;
            primed      <= 1'b0;
            locked_o    <= 1'b0;
            collision_o <= 1'b0;
            sync_err_o  <= 1'b0;
        end else begin
            if (any_trig) begin
                gap    <= GAP_W'(1);
                sel_o  <= first_idx;
                primed <= 1'b1;
            end else if (gap != GAP_MAX) begin
                gap <= gap + GAP_W'(1);
            end

            // Clear first; later set assignments override it
            if (clr_err) begin
                collision_o <= 1'b0;
                sync_err_o  <= 1'b0;
            end
            if (multi_trig) begin
                collision_o <= 1'b1;
            end

            case (state)
                ST_UNLOCKED: begin
                    if (any_trig) begin
                        if (well_spaced) begin
                            lock_cnt <= lock_cnt + LCK_W'(1);
                            if (lock_cnt == LCK_LAST) begin
                                state    <= ST_LOCKED;
                                locked_o <= 1'b1;
                            end
                        end else begin
                            lock_cnt <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bad_event) begin
                        state      <= ST_UNLOCKED;
                        lock_cnt   <= '0;
                        locked_o   <= 1'b0;
                        sync_err_o <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_UNLOCKED;
                    lock_cnt <= '0;
                    locked_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_mux_rr.sv
// Directed testbench for encoder_mux_rr with four encoders.
// Encoder k, cluster j carries address 100*k+j and size (k+j)%8.
// A non-triggering encoder shows pass 7.
module tb_encoder_mux_rr;

    localparam int NUM_ENC = 4;
    localparam int NUM_CL  = 16;
    localparam int ADR_W   = 11;
    localparam int CNT_W   = 3;
    localparam int PASS_W  = 3;

    logic                            clock4x = 1'b0;
    logic                            reset_n = 1'b0;
    logic                            clr_err = 1'b0;
    logic [NUM_ENC*PASS_W-1:0]       enc_pass;
    logic [NUM_ENC*NUM_CL*ADR_W-1:0] enc_adr;
    logic [NUM_ENC*NUM_CL*CNT_W-1:0] enc_cnt;
    logic [1:0]                      sel_o;
    logic [NUM_CL*ADR_W-1:0]         adr_o;
    logic [NUM_CL*CNT_W-1:0]         cnt_o;
    logic [PASS_W-1:0]               pass_o;
    logic                            locked_o;
    logic                            collision_o;
    logic                            sync_err_o;

    int checks   = 0;
    int failures = 0;

    encoder_mux_rr #(
        .NUM_ENC(NUM_ENC), .NUM_CL(NUM_CL), .ADR_W(ADR_W), .CNT_W(CNT_W),
        .PASS_W(PASS_W), .SEL_PASS(6), .SLOT_CYCLES(4), .LOCK_COUNT(4)
    ) dut (
        .clock4x(clock4x), .reset_n(reset_n), .enc_pass(enc_pass),
        .enc_adr(enc_adr), .enc_cnt(enc_cnt), .clr_err(clr_err),
        .sel_o(sel_o), .adr_o(adr_o), .cnt_o(cnt_o), .pass_o(pass_o),
        .locked_o(locked_o), .collision_o(collision_o), .sync_err_o(sync_err_o)
    );

    always #5 clock4x = ~clock4x;

    function automatic logic [NUM_CL*ADR_W-1:0] exp_adr(input int k);
        logic [NUM_CL*ADR_W-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_CL; j++) v[j*ADR_W +: ADR_W] = ADR_W'(100*k + j);
        return v;
    endfunction

    function automatic logic [NUM_CL*CNT_W-1:0] exp_cnt(input int k);
        logic [NUM_CL*CNT_W-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_CL; j++) v[j*CNT_W +: CNT_W] = CNT_W'((k + j) % 8);
        return v;
    endfunction

    task automatic tick;
        @(posedge clock4x);
        #1;
    endtask

    task automatic set_mask(input logic [NUM_ENC-1:0] m);
        for (int k = 0; k < NUM_ENC; k++)
            enc_pass[k*PASS_W +: PASS_W] = m[k] ? 3'd6 : 3'd7;
    endtask

    task automatic trig_once(input int k);
        logic [NUM_ENC-1:0] m;
        m = '0;
        m[k] = 1'b1;
        set_mask(m);
        tick();
        set_mask('0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        clr_err = 1'b0;
        set_mask('0);
        tick();
        reset_n = 1'b1;
    endtask

    // One unspaced trigger followed by four triggers at 4-cycle spacing
    task automatic lock_on(input int k);
        trig_once(k);
        repeat (4) begin
            idle(3);
            trig_once(k);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        set_mask('0);
        idle(2);
        checks++; if (sel_o !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_o); end
        checks++; if (adr_o !== '0) begin failures++; $display("FAIL reset_adr got=%h exp=0", adr_o); end
        checks++; if (cnt_o !== '0 || pass_o !== '0) begin failures++; $display("FAIL reset_cnt_pass cnt=%h pass=%0d exp=0", cnt_o, pass_o); end
        checks++; if ({locked_o, collision_o, sync_err_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {locked_o, collision_o, sync_err_o}); end
        reset_n = 1'b1;
    endtask

    task automatic test_alternate;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            if (n > 0) idle(2);
            trig_once(n % 2);
            checks++; if (sel_o !== 2'(n % 2)) begin failures++; $display("FAIL alt_sel n=%0d got=%0d exp=%0d", n, sel_o, n % 2); end
            checks++; if (locked_o !== (n == 4)) begin failures++; $display("FAIL alt_locked n=%0d got=%b exp=%b", n, locked_o, n == 4); end
            tick();
            checks++; if (adr_o !== exp_adr(n % 2)) begin failures++; $display("FAIL alt_adr n=%0d got=%h exp=%h", n, adr_o, exp_adr(n % 2)); end
            checks++; if (pass_o !== 3'd7) begin failures++; $display("FAIL alt_pass n=%0d got=%0d exp=7", n, pass_o); end
        end
        checks++; if (collision_o !== 1'b0 || sync_err_o !== 1'b0) begin failures++; $display("FAIL alt_flags coll=%b sync=%b exp=0,0", collision_o, sync_err_o); end
    endtask

    task automatic test_rotate;
        do_reset();
        for (int n = 0; n < 4; n++) begin
            trig_once(n);
            checks++; if (sel_o !== 2'(n)) begin failures++; $display("FAIL rot_sel n=%0d got=%0d exp=%0d", n, sel_o, n); end
            tick();
            checks++; if (adr_o !== exp_adr(n)) begin failures++; $display("FAIL rot_adr n=%0d got=%h exp=%h", n, adr_o, exp_adr(n)); end
            checks++; if (cnt_o !== exp_cnt(n)) begin failures++; $display("FAIL rot_cnt n=%0d got=%h exp=%h", n, cnt_o, exp_cnt(n)); end
            idle(2);
        end
        // One-cycle data latency from the selected encoder
        enc_adr[(3*NUM_CL + 0)*ADR_W +: ADR_W] = 11'd777;
        tick();
        checks++; if (adr_o[0 +: ADR_W] !== 11'd777) begin failures++; $display("FAIL rot_latency got=%0d exp=777", adr_o[0 +: ADR_W]); end
        enc_adr[(3*NUM_CL + 0)*ADR_W +: ADR_W] = 11'd300;
        checks++; if (collision_o !== 1'b0) begin failures++; $display("FAIL rot_coll got=%b exp=0", collision_o); end
    endtask

    task automatic test_collision;
        do_reset();
        set_mask(4'b0110);
        tick();
        set_mask('0);
        checks++; if (sel_o !== 2'd1) begin failures++; $display("FAIL coll_sel got=%0d exp=1", sel_o); end
        checks++; if (collision_o !== 1'b1) begin failures++; $display("FAIL coll_set got=%b exp=1", collision_o); end
        tick();
        checks++; if (collision_o !== 1'b1) begin failures++; $display("FAIL coll_sticky got=%b exp=1", collision_o); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (collision_o !== 1'b0) begin failures++; $display("FAIL coll_clear got=%b exp=0", collision_o); end
        clr_err = 1'b1;
        set_mask(4'b1001);
        tick();
        clr_err = 1'b0;
        set_mask('0);
        checks++; if (collision_o !== 1'b1) begin failures++; $display("FAIL coll_set_wins got=%b exp=1", collision_o); end
        checks++; if (sel_o !== 2'd0) begin failures++; $display("FAIL coll_sel_low got=%0d exp=0", sel_o); end
    endtask

    task automatic test_late_trigger;
        do_reset();
        lock_on(0);
        checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL late_lock got=%b exp=1", locked_o); end
        idle(4);
        trig_once(0);
        checks++; if (locked_o !== 1'b0 || sync_err_o !== 1'b1) begin failures++; $display("FAIL late_drop locked=%b sync=%b exp=0,1", locked_o, sync_err_o); end
        for (int n = 1; n <= 4; n++) begin
            idle(3);
            trig_once(0);
            checks++; if (locked_o !== (n == 4)) begin failures++; $display("FAIL late_relock n=%0d got=%b exp=%b", n, locked_o, n == 4); end
        end
        checks++; if (sync_err_o !== 1'b1) begin failures++; $display("FAIL late_sync_sticky got=%b exp=1", sync_err_o); end
    endtask

    task automatic test_missing_trigger;
        do_reset();
        lock_on(2);
        idle(4);
        checks++; if (locked_o !== 1'b1 || sync_err_o !== 1'b0) begin failures++; $display("FAIL miss_hold locked=%b sync=%b exp=1,0", locked_o, sync_err_o); end
        idle(1);
        checks++; if (locked_o !== 1'b0 || sync_err_o !== 1'b1) begin failures++; $display("FAIL miss_drop locked=%b sync=%b exp=0,1", locked_o, sync_err_o); end
        idle(30);
        checks++; if (dut.gap !== 4'd15) begin failures++; $display("FAIL miss_gap_sat got=%0d exp=15", dut.gap); end
    endtask

    task automatic test_reset_midlock;
        do_reset();
        lock_on(1);
        tick();
        checks++; if (locked_o !== 1'b1 || adr_o !== exp_adr(1)) begin failures++; $display("FAIL mid_prelock locked=%b adr0=%0d exp=1,100", locked_o, adr_o[0 +: ADR_W]); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if ({locked_o, collision_o, sync_err_o} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b exp=000", {locked_o, collision_o, sync_err_o}); end
        checks++; if (adr_o !== '0 || cnt_o !== '0 || pass_o !== '0 || sel_o !== 2'd0) begin failures++; $display("FAIL mid_data adr0=%0d sel=%0d pass=%0d exp=0", adr_o[0 +: ADR_W], sel_o, pass_o); end
        trig_once(1);
        for (int n = 1; n <= 4; n++) begin
            idle(3);
            trig_once(1);
            checks++; if (locked_o !== (n == 4)) begin failures++; $display("FAIL mid_relock n=%0d got=%b exp=%b", n, locked_o, n == 4); end
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_ENC; k++) begin
            enc_adr[k*NUM_CL*ADR_W +: NUM_CL*ADR_W] = exp_adr(k);
            enc_cnt[k*NUM_CL*CNT_W +: NUM_CL*CNT_W] = exp_cnt(k);
        end
        set_mask('0);
        test_reset();
        test_alternate();
        test_rotate();
        test_collision();
        test_late_trigger();
        test_missing_trigger();
        test_reset_midlock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
